mem_wb_pipe_stage: RTL and testbench

- Parametrised, elastic successor of the fixed MEM/WB latch. Carries control, memory read data, ALU result and destination register from MEM to WB.
- Uses a valid/ready handshake instead of free-running capture.
- Adds back-pressure through an optional skid entry, a synchronous flush, bubble-safe control gating and a saturating stall counter.
- Sits between the data-memory stage and the register-file write port.

---
 rtl/mem_wb_pipe_stage_pkg.sv | 15 +
 rtl/mem_wb_pipe_stage_if.sv | 30 +++
 rtl/mem_wb_pipe_stage_payload_entry.sv | 29 ++
 rtl/mem_wb_pipe_stage.sv | 131 +++++++++++++
 tb/tb_mem_wb_pipe_stage.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_pipe_stage_pkg.sv
// Shared MEM/WB pipeline definitions: control-bit indices, default widths
// and the elastic-buffer state encodings.
package mem_wb_pipe_stage_pkg;

  localparam int unsigned CTRL_REG_WRITE  = 0;
  localparam int unsigned CTRL_MEM_TO_REG = 1;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_REG_W  = 5;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

endpackage

// File: rtl/mem_wb_pipe_stage_if.sv
// MEM->WB handshake bundle: upstream valid/ready/payload and downstream
// valid/ready/payload. master is the environment side, slave the stage.
interface mem_wb_pipe_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned REG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_read_data;
  logic [DATA_W-1:0] in_alu_result;
  logic [REG_W-1:0]  in_write_reg;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_read_data;
  logic [DATA_W-1:0] out_alu_result;
  logic [REG_W-1:0]  out_write_reg;

  modport master (
    output in_valid, in_ctrl, in_read_data, in_alu_result, in_write_reg, out_ready,
    input  in_ready, out_valid, out_ctrl, out_read_data, out_alu_result, out_write_reg
  );

  modport slave (
    input  in_valid, in_ctrl, in_read_data, in_alu_result, in_write_reg, out_ready,
    output in_ready, out_valid, out_ctrl, out_read_data, out_alu_result, out_write_reg
  );
endinterface

// File: rtl/mem_wb_pipe_stage_payload_entry.sv
// One valid bit plus payload register. Load wins over clear for the valid
// bit; clear never touches the payload, so data holds while invalid.
module pipe_payload_entry #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      if (load) begin
        q     <= d;
        valid <= 1'b1;
      end else if (clear) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// Elastic MEM/WB stage: valid/ready handshake, optional skid entry,
// synchronous flush, bubble-gated control and a saturating stall counter.
module mem_wb_pipe_stage
  import mem_wb_pipe_stage_pkg::*;
#(
  parameter int unsigned DATA_W      = DEFAULT_DATA_W,
  parameter int unsigned CTRL_W      = 2,
  parameter int unsigned REG_W       = DEFAULT_REG_W,
  parameter int unsigned SKID        = 1,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  mem_wb_pipe_stage_if.slave     bus,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int unsigned PL_W = CTRL_W + 2 * DATA_W + REG_W;

  logic [PL_W-1:0]   in_pl;
  logic [PL_W-1:0]   head_pl;
  logic              head_valid;
  logic              in_ready_w;
  logic              in_acc;
  logic              out_acc;
  logic [CTRL_W-1:0] head_ctrl;

  assign in_pl   = {bus.in_ctrl, bus.in_read_data, bus.in_alu_result, bus.in_write_reg};
  assign in_acc  = bus.in_valid & in_ready_w;
  assign out_acc = head_valid & bus.out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic [1:0]      state;
      logic [1:0]      state_nxt;
      logic            head_load;
      logic            head_clear;
      logic            head_from_skid;
      logic            skid_load;
      logic            skid_clear;
      logic            skid_valid;
      logic [PL_W-1:0] skid_pl;
      logic [PL_W-1:0] head_d;

      always_comb begin
        state_nxt      = state;
        head_load      = 1'b0;
        head_clear     = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        case (state)
          EMPTY: if (in_acc) begin
            head_load = 1'b1;
            state_nxt = ONE;
          end
          ONE: begin
            if (in_acc && out_acc) begin
              head_load = 1'b1;
            end else if (in_acc) begin
              skid_load = 1'b1;
              state_nxt = FULL;
            end else if (out_acc) begin
              head_clear = 1'b1;
              state_nxt  = EMPTY;
            end
          end
          FULL: if (out_acc) begin
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_nxt      = ONE;
          end
          default: state_nxt = EMPTY;
        endcase
        // Flush discards everything, including a same-cycle accept.
        if (flush) begin
          head_load  = 1'b0;
          skid_load  = 1'b0;
          head_clear = 1'b1;
          skid_clear = 1'b1;
          state_nxt  = EMPTY;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
      end

      always_ff @(posedge clk) begin
        if (!reset) assert ((state == FULL) == skid_valid);
      end

      assign head_d     = head_from_skid ? skid_pl : in_pl;
      assign in_ready_w = (state != FULL);

      pipe_payload_entry #(.W(PL_W)) u_head (
        .clk(clk), .reset(reset), .load(head_load), .clear(head_clear),
        .d(head_d), .valid(head_valid), .q(head_pl)
      );

      pipe_payload_entry #(.W(PL_W)) u_skid (
        .clk(clk), .reset(reset), .load(skid_load), .clear(skid_clear),
        .d(in_pl), .valid(skid_valid), .q(skid_pl)
      );
    end else begin : g_single
      assign in_ready_w = ~head_valid | bus.out_ready;

      pipe_payload_entry #(.W(PL_W)) u_head (
        .clk(clk), .reset(reset), .load(in_acc & ~flush), .clear(flush | out_acc),
        .d(in_pl), .valid(head_valid), .q(head_pl)
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (head_valid && !bus.out_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

  assign {head_ctrl, bus.out_read_data, bus.out_alu_result, bus.out_write_reg} = head_pl;
  assign bus.out_ctrl  = head_ctrl & {CTRL_W{head_valid}};
  assign bus.out_valid = head_valid;
  assign bus.in_ready  = in_ready_w;

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Bench for mem_wb_pipe_stage: SKID=1, SKID=0 and a 3-bit-counter SKID=1
// build, checked against a queue-based model of the stage.
module tb_mem_wb_pipe_stage;

  typedef struct packed {
    logic [1:0]  ctrl;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
  } pl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush_a, flush_b;
  logic [15:0] stall_a, stall_b;
  logic [2:0]  stall_c;

  mem_wb_pipe_stage_if #(.DATA_W(32), .CTRL_W(2), .REG_W(5)) bus_a ();
  mem_wb_pipe_stage_if #(.DATA_W(32), .CTRL_W(2), .REG_W(5)) bus_b ();
  mem_wb_pipe_stage_if #(.DATA_W(32), .CTRL_W(2), .REG_W(5)) bus_c ();

  assign bus_c.in_valid      = bus_a.in_valid;
  assign bus_c.in_ctrl       = bus_a.in_ctrl;
  assign bus_c.in_read_data  = bus_a.in_read_data;
  assign bus_c.in_alu_result = bus_a.in_alu_result;
  assign bus_c.in_write_reg  = bus_a.in_write_reg;
  assign bus_c.out_ready     = bus_a.out_ready;

  mem_wb_pipe_stage #(.DATA_W(32), .CTRL_W(2), .REG_W(5), .SKID(1), .STALL_CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .flush(flush_a), .bus(bus_a.slave), .stall_cycles(stall_a));
  mem_wb_pipe_stage #(.DATA_W(32), .CTRL_W(2), .REG_W(5), .SKID(0), .STALL_CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .flush(flush_b), .bus(bus_b.slave), .stall_cycles(stall_b));
  mem_wb_pipe_stage #(.DATA_W(32), .CTRL_W(2), .REG_W(5), .SKID(1), .STALL_CNT_W(3)) dut_c (
    .clk(clk), .reset(reset), .flush(flush_a), .bus(bus_c.slave), .stall_cycles(stall_c));

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Model: a FIFO of capacity 2 (SKID=1) or 1 (SKID=0) plus last head seen.
  pl_t qa[$];
  pl_t qb[$];
  pl_t last_a, last_b;
  int unsigned sa, sb, sc;

  function automatic pl_t rand_pl();
    pl_t p;
    p.ctrl = 2'($urandom);
    p.rd   = $urandom;
    p.alu  = $urandom;
    p.wr   = 5'($urandom);
    return p;
  endfunction

  function automatic logic ready_a_m();
    return qa.size() < 2;
  endfunction

  function automatic logic ready_b_m();
    return (qb.size() == 0) || bus_b.out_ready;
  endfunction

  function automatic pl_t head_a_m();
    return (qa.size() != 0) ? qa[0] : last_a;
  endfunction

  function automatic pl_t head_b_m();
    return (qb.size() != 0) ? qb[0] : last_b;
  endfunction

  task automatic drive_a(input logic v, input pl_t p, input logic rdy, input logic fl);
    bus_a.in_valid = v; bus_a.in_ctrl = p.ctrl; bus_a.in_read_data = p.rd;
    bus_a.in_alu_result = p.alu; bus_a.in_write_reg = p.wr;
    bus_a.out_ready = rdy; flush_a = fl;
  endtask

  task automatic drive_b(input logic v, input pl_t p, input logic rdy, input logic fl);
    bus_b.in_valid = v; bus_b.in_ctrl = p.ctrl; bus_b.in_read_data = p.rd;
    bus_b.in_alu_result = p.alu; bus_b.in_write_reg = p.wr;
    bus_b.out_ready = rdy; flush_b = fl;
  endtask

  // Advance one clock and step the model with the inputs held across the edge.
  task automatic tick();
    logic acc_a, pop_a, acc_b, pop_b;
    pl_t  pa, pb;
    #1;
    acc_a = bus_a.in_valid && ready_a_m();
    pop_a = (qa.size() != 0) && bus_a.out_ready;
    acc_b = bus_b.in_valid && ready_b_m();
    pop_b = (qb.size() != 0) && bus_b.out_ready;
    pa = {bus_a.in_ctrl, bus_a.in_read_data, bus_a.in_alu_result, bus_a.in_write_reg};
    pb = {bus_b.in_ctrl, bus_b.in_read_data, bus_b.in_alu_result, bus_b.in_write_reg};
    @(posedge clk);
    if (reset) begin
      qa.delete(); qb.delete(); last_a = '0; last_b = '0; sa = 0; sb = 0; sc = 0;
    end else begin
      if (qa.size() != 0 && !bus_a.out_ready) begin
        if (sa < 65535) sa++;
        if (sc < 7) sc++;
      end
      if (qb.size() != 0 && !bus_b.out_ready && sb < 65535) sb++;
      if (flush_a) qa.delete();
      else begin
        if (pop_a) void'(qa.pop_front());
        if (acc_a) qa.push_back(pa);
      end
      if (flush_b) qb.delete();
      else begin
        if (pop_b) void'(qb.pop_front());
        if (acc_b) qb.push_back(pb);
      end
      if (qa.size() != 0) last_a = qa[0];
      if (qb.size() != 0) last_b = qb[0];
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_a(1'b1, rand_pl(), 1'b0, 1'b0);
    drive_b(1'b1, rand_pl(), 1'b0, 1'b0);
    repeat (2) begin
      tick();
      vectors++;
      if ({bus_a.out_valid, bus_a.out_ctrl, bus_a.out_read_data, bus_a.out_alu_result,
           bus_a.out_write_reg, stall_a, bus_a.in_ready} !== {1'b0, 71'd0, 16'd0, 1'b1}) begin
        miscompares++;
        $display("FAIL reset_a: got v=%b c=%b rd=%h alu=%h wr=%h st=%0d rdy=%b want zeros rdy=1",
          bus_a.out_valid, bus_a.out_ctrl, bus_a.out_read_data, bus_a.out_alu_result,
          bus_a.out_write_reg, stall_a, bus_a.in_ready);
      end
      vectors++;
      if ({bus_b.out_valid, bus_b.out_ctrl, bus_b.out_read_data, bus_b.out_alu_result,
           bus_b.out_write_reg, stall_b, bus_b.in_ready} !== {1'b0, 71'd0, 16'd0, 1'b1}) begin
        miscompares++;
        $display("FAIL reset_b: got v=%b c=%b rd=%h alu=%h st=%0d rdy=%b want zeros rdy=1",
          bus_b.out_valid, bus_b.out_ctrl, bus_b.out_read_data, bus_b.out_alu_result,
          stall_b, bus_b.in_ready);
      end
    end
    reset = 1'b0;
    drive_a(1'b0, '0, 1'b1, 1'b0);
    drive_b(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_single();
    pl_t p;
    p = {2'b11, 32'hDEADBEEF, 32'h10, 5'd7};
    drive_a(1'b1, p, 1'b1, 1'b0);
    tick();
    drive_a(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if ({bus_a.out_valid, bus_a.out_ctrl, bus_a.out_read_data, bus_a.out_alu_result,
         bus_a.out_write_reg} !== {1'b1, p}) begin
      miscompares++;
      $display("FAIL single: got v=%b c=%b rd=%h alu=%h wr=%0d want v=1 %h", bus_a.out_valid,
        bus_a.out_ctrl, bus_a.out_read_data, bus_a.out_alu_result, bus_a.out_write_reg, p);
    end
    tick();
    vectors++;
    if (bus_a.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drain: got out_valid=%b want 0", bus_a.out_valid);
    end
  endtask

  task automatic test_backpressure();
    pl_t p;
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'h1; exp_seq[1] = 32'h2; exp_seq[2] = 32'h3;
    for (int i = 0; i < 2; i++) begin
      p = rand_pl(); p.alu = 32'(i + 1);
      drive_a(1'b1, p, 1'b0, 1'b0);
      tick();
    end
    p = rand_pl(); p.alu = 32'h3;
    drive_a(1'b1, p, 1'b0, 1'b0);
    #1;
    vectors++;
    if (bus_a.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_full_ready: got in_ready=%b want 0", bus_a.in_ready);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (bus_a.out_alu_result !== 32'h1 || bus_a.out_valid !== 1'b1 || stall_a !== 16'(sa)) begin
        miscompares++;
        $display("FAIL bp_hold: got alu=%h v=%b stall=%0d want alu=1 v=1 stall=%0d",
          bus_a.out_alu_result, bus_a.out_valid, stall_a, sa);
      end
    end
    vectors++;
    if (stall_c !== 3'd7 || sc != 7) begin
      miscompares++;
      $display("FAIL stall_saturate: got %0d want 7", stall_c);
    end
    bus_a.out_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      vectors++;
      if (bus_a.out_alu_result !== exp_seq[i] || bus_a.out_alu_result !== head_a_m().alu) begin
        miscompares++;
        $display("FAIL bp_order: got alu=%h want %h", bus_a.out_alu_result, exp_seq[i]);
      end
      if (i == 1) bus_a.in_valid = 1'b1;
      else        bus_a.in_valid = 1'b0;
    end
    tick();
    vectors++;
    if (bus_a.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_empty: got out_valid=%b want 0", bus_a.out_valid);
    end
  endtask

  task automatic test_stream();
    pl_t p;
    for (int i = 0; i < 16; i++) begin
      p = rand_pl(); p.alu = 32'(i);
      drive_a(1'b1, p, 1'b1, 1'b0);
      #1;
      vectors++;
      if (bus_a.in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_ready: i=%0d got in_ready=%b want 1", i, bus_a.in_ready);
      end
      tick();
      vectors++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_alu_result !== 32'(i)) begin
        miscompares++;
        $display("FAIL stream_data: got v=%b alu=%h want v=1 alu=%h", bus_a.out_valid,
          bus_a.out_alu_result, 32'(i));
      end
    end
    drive_a(1'b0, '0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_flush();
    pl_t p;
    for (int i = 0; i < 2; i++) begin
      p = rand_pl(); p.ctrl = 2'b11; p.alu = 32'hA0 + 32'(i);
      drive_a(1'b1, p, 1'b0, 1'b0);
      tick();
    end
    p = rand_pl(); p.alu = 32'h55;
    drive_a(1'b1, p, 1'b0, 1'b1);
    tick();
    vectors++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_ctrl !== 2'b00 || bus_a.in_ready !== 1'b1 ||
        bus_a.out_alu_result !== 32'hA0) begin
      miscompares++;
      $display("FAIL flush_full: got v=%b c=%b rdy=%b alu=%h want 0 00 1 a0", bus_a.out_valid,
        bus_a.out_ctrl, bus_a.in_ready, bus_a.out_alu_result);
    end
    // Flush while ONE with an accept in the same cycle.
    p.alu = 32'h77; drive_a(1'b1, p, 1'b0, 1'b0); tick();
    p.alu = 32'h66; drive_a(1'b1, p, 1'b0, 1'b1); tick();
    drive_a(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus_a.out_valid !== 1'b0 || bus_a.out_alu_result !== 32'h77) begin
        miscompares++;
        $display("FAIL flush_discard: got v=%b alu=%h want v=0 alu=77", bus_a.out_valid,
          bus_a.out_alu_result);
      end
    end
  endtask

  task automatic test_bubble();
    pl_t p;
    p = rand_pl(); p.ctrl = 2'b11; p.alu = 32'hABC;
    drive_a(1'b1, p, 1'b1, 1'b0);
    tick();
    drive_a(1'b0, rand_pl(), 1'b1, 1'b0);
    tick();
    vectors++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_ctrl !== 2'b00 || bus_a.out_alu_result !== 32'hABC) begin
      miscompares++;
      $display("FAIL bubble: got v=%b c=%b alu=%h want 0 00 abc", bus_a.out_valid,
        bus_a.out_ctrl, bus_a.out_alu_result);
    end
  endtask

  task automatic test_skid0();
    pl_t p;
    p = rand_pl();
    drive_b(1'b1, p, 1'b0, 1'b0);
    tick();
    drive_b(1'b1, rand_pl(), 1'b0, 1'b0);
    #1;
    vectors++;
    if (bus_b.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL skid0_stall_ready: got in_ready=%b want 0", bus_b.in_ready);
    end
    bus_b.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus_b.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL skid0_comb_ready: got in_ready=%b want 1", bus_b.in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      p = rand_pl(); p.alu = 32'h100 + 32'(i);
      drive_b(1'b1, p, 1'b1, 1'b0);
      tick();
      vectors++;
      if (bus_b.out_valid !== 1'b1 || bus_b.out_alu_result !== 32'h100 + 32'(i) ||
          stall_b !== 16'(sb)) begin
        miscompares++;
        $display("FAIL skid0_b2b: got v=%b alu=%h stall=%0d want v=1 alu=%h stall=%0d",
          bus_b.out_valid, bus_b.out_alu_result, stall_b, 32'h100 + 32'(i), sb);
      end
    end
    drive_b(1'b0, '0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    drive_a(1'b1, rand_pl(), 1'b0, 1'b0);
    drive_b(1'b1, rand_pl(), 1'b0, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_alu_result !== 32'd0 || stall_a !== 16'd0 ||
        bus_a.in_ready !== 1'b1 || bus_b.out_valid !== 1'b0 || stall_b !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got va=%b alu=%h sta=%0d rdy=%b vb=%b stb=%0d want 0 0 0 1 0 0",
        bus_a.out_valid, bus_a.out_alu_result, stall_a, bus_a.in_ready, bus_b.out_valid, stall_b);
    end
    drive_a(1'b0, '0, 1'b1, 1'b0);
    drive_b(1'b0, '0, 1'b1, 1'b0);
    tick();
    vectors++;
    if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_drop: got va=%b vb=%b want 0 0", bus_a.out_valid, bus_b.out_valid);
    end
  endtask

  task automatic test_random();
    pl_t ea, eb;
    logic va, vb;
    for (int n = 0; n < 600; n++) begin
      drive_a($urandom_range(0, 3) != 0, rand_pl(), $urandom_range(0, 2) != 0,
              $urandom_range(0, 24) == 0);
      drive_b($urandom_range(0, 3) != 0, rand_pl(), $urandom_range(0, 2) != 0,
              $urandom_range(0, 24) == 0);
      reset = ($urandom_range(0, 149) == 0);
      #1;
      vectors++;
      if (bus_a.in_ready !== ready_a_m() || bus_b.in_ready !== ready_b_m()) begin
        miscompares++;
        $display("FAIL rand_ready: got a=%b b=%b want a=%b b=%b", bus_a.in_ready,
          bus_b.in_ready, ready_a_m(), ready_b_m());
      end
      tick();
      ea = head_a_m(); va = (qa.size() != 0);
      eb = head_b_m(); vb = (qb.size() != 0);
      vectors++;
      if ({bus_a.out_valid, bus_a.out_ctrl, bus_a.out_read_data, bus_a.out_alu_result,
           bus_a.out_write_reg} !== {va, va ? ea.ctrl : 2'b00, ea.rd, ea.alu, ea.wr}) begin
        miscompares++;
        $display("FAIL rand_out_a: got v=%b c=%b rd=%h alu=%h wr=%h want v=%b %h", bus_a.out_valid,
          bus_a.out_ctrl, bus_a.out_read_data, bus_a.out_alu_result, bus_a.out_write_reg, va, ea);
      end
      vectors++;
      if ({bus_b.out_valid, bus_b.out_ctrl, bus_b.out_read_data, bus_b.out_alu_result,
           bus_b.out_write_reg} !== {vb, vb ? eb.ctrl : 2'b00, eb.rd, eb.alu, eb.wr}) begin
        miscompares++;
        $display("FAIL rand_out_b: got v=%b c=%b rd=%h alu=%h wr=%h want v=%b %h", bus_b.out_valid,
          bus_b.out_ctrl, bus_b.out_read_data, bus_b.out_alu_result, bus_b.out_write_reg, vb, eb);
      end
      vectors++;
      if (stall_a !== 16'(sa) || stall_b !== 16'(sb) || stall_c !== 3'(sc)) begin
        miscompares++;
        $display("FAIL rand_stall: got a=%0d b=%0d c=%0d want a=%0d b=%0d c=%0d",
          stall_a, stall_b, stall_c, sa, sb, sc);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    last_a = '0; last_b = '0; sa = 0; sb = 0; sc = 0;
    reset = 1'b1;
    drive_a(1'b0, '0, 1'b1, 1'b0);
    drive_b(1'b0, '0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_flush();
    test_bubble();
    test_skid0();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
